lcd_bus_arbiter: RTL and testbench

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

---
 rtl/lcd_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// lcd_bus_arbiter: two-port round-robin arbiter driving an HD44780-style LCD
// write bus, with power-up delay and built-in init command sequence.
// Revision: 1.0
// ============================================================================
module lcd_bus_arbiter #(
    parameter int SETUP_CYC      = 2,
    parameter int PULSE_CYC      = 3,
    parameter int HOLD_CYC       = 4,
    parameter int CLEAR_WAIT_CYC = 10,
    parameter int POWERUP_CYC    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       busy
);

    localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_B = (HOLD_CYC > CLEAR_WAIT_CYC) ? HOLD_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAXP  = (MAX_C > POWERUP_CYC) ? MAX_C : POWERUP_CYC;
    localparam int CW    = $clog2(MAXP + 1);

    localparam logic [CW-1:0] C_ONE       = CW'(1);
    localparam logic [CW-1:0] C_PWR_LAST  = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] C_SET_LAST  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] C_PUL_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] C_HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] C_CLR_LAST  = CW'(CLEAR_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_INIT  = 3'd1,
        S_IDLE  = 3'd2,
        S_SETUP = 3'd3,
        S_PULSE = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    init_idx_q;
    logic          ptr_q;
    logic          hold_long_q;

    logic          win1_d;
    logic          gnt_rs_d;
    logic [7:0]    gnt_data_d;
    logic [7:0]    init_byte_d;
    logic [CW-1:0] hold_last_d;

    function automatic logic is_clear(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02);
    endfunction

    // ptr_q holds the last granted port; a tie goes to the other one.
    assign win1_d     = req1 && (!req0 || !ptr_q);
    assign gnt_rs_d   = win1_d ? rs1 : rs0;
    assign gnt_data_d = win1_d ? data1 : data0;

    always_comb begin
        init_byte_d = 8'h01;
        case (init_idx_q)
            2'd0:    init_byte_d = 8'h38;
            2'd1:    init_byte_d = 8'h06;
            2'd2:    init_byte_d = 8'h0C;
            default: init_byte_d = 8'h01;
        endcase
    end

    assign hold_last_d = hold_long_q ? C_CLR_LAST : C_HOLD_LAST;
    assign lcd_rw      = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            init_idx_q  <= 2'd0;
            ptr_q       <= 1'b1;
            hold_long_q <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_data    <= 8'h00;
            lcd_en      <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state_q)
                S_PWRUP: begin
                    if (cnt_q == C_PWR_LAST) begin
                        state_q <= S_INIT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                    end
                end
                S_INIT: begin
                    lcd_rs      <= 1'b0;
                    lcd_data    <= init_byte_d;
                    hold_long_q <= is_clear(1'b0, init_byte_d);
                    cnt_q       <= '0;
                    state_q     <= S_SETUP;
                end
                S_IDLE: begin
                    if (req0 || req1) begin
                        lcd_rs      <= gnt_rs_d;
                        lcd_data    <= gnt_data_d;
                        hold_long_q <= is_clear(gnt_rs_d, gnt_data_d);
                        ack0        <= !win1_d;
                        ack1        <= win1_d;
                        ptr_q       <= win1_d;
                        cnt_q       <= '0;
                        busy        <= 1'b1;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == C_SET_LAST) begin
                        cnt_q   <= '0;
                        lcd_en  <= 1'b1;
                        state_q <= S_PULSE;
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == C_PUL_LAST) begin
                        cnt_q   <= '0;
                        lcd_en  <= 1'b0;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == hold_last_d) begin
                        cnt_q <= '0;
                        if (!init_done && init_idx_q != 2'd3) begin
                            init_idx_q <= init_idx_q + 2'd1;
                            state_q    <= S_INIT;
                        end else begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                    end
                end
                default: begin
                    state_q <= S_PWRUP;
                    cnt_q   <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_lcd_bus_arbiter: directed stimulus with queue-based scoreboard monitors.
// Revision: 1.0
// ============================================================================
module tb_lcd_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, rs0, rs1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, lcd_rs, lcd_rw, lcd_en, init_done, busy;
    logic [7:0] lcd_data;

    lcd_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .rs0       (rs0),
        .rs1       (rs1),
        .data0     (data0),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data),
        .init_done (init_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         pulse;  // 0 = do not check
        int         hold;   // 0 = do not check
    } wr_t;

    wr_t exp_wr[$];
    int  exp_gnt[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic rs, input logic [7:0] d, input int p, input int h);
        wr_t e;
        e.rs = rs; e.data = d; e.pulse = p; e.hold = h;
        exp_wr.push_back(e);
    endtask

    task automatic push_init();
        push_wr(1'b0, 8'h38, 3, 0);
        push_wr(1'b0, 8'h06, 3, 0);
        push_wr(1'b0, 8'h0C, 3, 0);
        push_wr(1'b0, 8'h01, 3, 10);
    endtask

    task automatic wait_ack(input int budget, output int port);
        port = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                port = ack1 ? 1 : 0;
                return;
            end
        end
        chk("ack_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) return;
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},   {31'd0, lcd_en},    32'd0);
        chk({tag, "_rs"},   {31'd0, lcd_rs},    32'd0);
        chk({tag, "_rw"},   {31'd0, lcd_rw},    32'd0);
        chk({tag, "_data"}, {24'd0, lcd_data},  32'd0);
        chk({tag, "_ack"},  {30'd0, ack1, ack0}, 32'd0);
        chk({tag, "_init"}, {31'd0, init_done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy},      32'd1);
    endtask

    // Write monitor: one expected entry per lcd_en pulse.
    initial begin : mon_wr
        wr_t        e;
        int         np, nh;
        logic       stable;
        logic       rs_s;
        logic [7:0] d_s;
        @(negedge clk);
        forever begin
            if (lcd_en !== 1'b1) begin
                @(negedge clk);
                continue;
            end
            if (exp_wr.size() == 0) begin
                chk("unexpected_write", {24'd0, lcd_data}, 32'hFFFF);
                e.rs = lcd_rs; e.data = lcd_data; e.pulse = 0; e.hold = 0;
            end else begin
                e = exp_wr.pop_front();
                chk("wr_rs",   {31'd0, lcd_rs},   {31'd0, e.rs});
                chk("wr_data", {24'd0, lcd_data}, {24'd0, e.data});
            end
            rs_s = lcd_rs; d_s = lcd_data; stable = 1'b1; np = 0;
            while (lcd_en === 1'b1) begin
                np++;
                if (lcd_rs !== rs_s || lcd_data !== d_s) stable = 1'b0;
                @(negedge clk);
            end
            if (e.pulse != 0) begin
                chk("wr_pulse_len", np, e.pulse);
                chk("wr_stable", {31'd0, stable}, 32'd1);
            end
            nh = 0;
            while (lcd_en === 1'b0 && busy === 1'b1) begin
                nh++;
                @(negedge clk);
            end
            if (e.hold != 0) chk("wr_hold_len", nh, e.hold);
        end
    end

    // Ack monitor: one expected port per ack pulse.
    initial begin : mon_ack
        logic prev;
        @(negedge clk);
        prev = 1'b0;
        forever begin
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                chk("ack_one_cycle", {31'd0, prev}, 32'd0);
                chk("ack_init_done", {31'd0, init_done}, 32'd1);
                if (ack0 && ack1) begin
                    chk("ack_both", 32'd1, 32'd0);
                end else if (exp_gnt.size() == 0) begin
                    chk("unexpected_ack", {31'd0, ack1}, 32'hFF);
                end else begin
                    chk("ack_port", {31'd0, ack1}, exp_gnt.pop_front());
                end
            end
            prev = (ack0 === 1'b1) || (ack1 === 1'b1);
            @(negedge clk);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, port, t_prev;
        int ng[2];
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");

        // Power-up and init, with req0 pending throughout.
        push_init();
        push_wr(1'b1, 8'h55, 3, 4);
        exp_gnt.push_back(0);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h55;
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 8) chk("pwrup_data", {24'd0, lcd_data}, 32'h00);
            if (lcd_en === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("pwrup_en_rise", n, 11);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                n = 1;
                break;
            end
        end
        chk("init_done_seen", n, 1);
        chk("init_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("first_idle_grant", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        wait_idle(50);

        // Single data write from port 0: timing after the ack edge.
        push_wr(1'b1, 8'h41, 3, 4);
        exp_gnt.push_back(0);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
        @(negedge clk);
        chk("w41_ack", {31'd0, ack0}, 32'd1);
        chk("w41_data", {24'd0, lcd_data}, 32'h41);
        chk("w41_rs", {31'd0, lcd_rs}, 32'd1);
        req0 = 1'b0; data0 = 8'hEE;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) @(negedge clk);
            chk($sformatf("w41_en_c%0d", i), {31'd0, lcd_en}, (i >= 3 && i <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("w41_busy_c%0d", i), {31'd0, busy}, (i <= 9) ? 32'd1 : 32'd0);
        end

        // Clear-display command from port 1: long hold.
        push_wr(1'b0, 8'h01, 3, 10);
        exp_gnt.push_back(1);
        req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
        wait_ack(20, port);
        req1 = 1'b0;
        wait_idle(50);

        // Both ports contending: alternate, 10-cycle spacing.
        for (int k = 0; k < 4; k++) begin
            exp_gnt.push_back(k % 2);
            push_wr(1'b1, (k % 2) ? 8'h31 : 8'h30, 3, 4);
        end
        ng[0] = 0; ng[1] = 0; t_prev = 0;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h30;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h31;
        for (int k = 0; k < 4; k++) begin
            wait_ack(30, port);
            if (port < 0) break;
            if (k > 0) chk("rr_spacing", cyc - t_prev, 10);
            t_prev = cyc;
            ng[port]++;
            if (ng[port] == 2) begin
                if (port == 0) req0 = 1'b0;
                else           req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(50);

        // Reset while lcd_en is high; a new request waits out the re-init.
        push_wr(1'b1, 8'h77, 0, 0);
        exp_gnt.push_back(0);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h77;
        wait_ack(20, port);
        req0 = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_en === 1'b1) begin
                n = 1;
                break;
            end
        end
        chk("abort_en_seen", n, 1);
        reset = 1'b1;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h66;
        push_init();
        push_wr(1'b1, 8'h66, 3, 4);
        exp_gnt.push_back(0);
        @(negedge clk);
        chk_reset_outputs("abort");
        reset = 1'b0;
        wait_ack(200, port);
        chk("abort_regrant_port", port, 0);
        req0 = 1'b0;
        wait_idle(50);
        repeat (3) @(negedge clk);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("gnt_queue_empty", exp_gnt.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
